img_rom_arbiter: RTL and testbench
==================================

IMG_ROM_ARBITER -- requirements
Module: img_rom_arbiter

Interface
REQ-001 SHALL have parameter IMG_W, default 320, source image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 240, source image height in pixels.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port disp_en  input  1  display active-video flag from the VGA timing generator.
REQ-006 SHALL have ports x_pixel, y_pixel  input  10 each  display coordinate, 640x480 space.
REQ-007 SHALL have ports r_port, g_port, b_port  output  4 each  RGB444 pixel to the DAC.
REQ-008 SHALL have port rom_addr  output  17  registered address to the image ROM, which has 1-cycle registered read.
REQ-009 SHALL have port rom_data  input  16  RGB565 word from the ROM.
REQ-010 SHALL have ports aux_req  input  1,  aux_addr  input  17  auxiliary read request; aux_addr stable while aux_req high.
REQ-011 SHALL have port aux_gnt  output  1  combinational; high in the cycle the aux request is accepted.
REQ-012 SHALL have ports aux_rvalid  output  1,  aux_rdata  output  16  aux read return.

Function
REQ-013 SHALL upscale 2x: source address = IMG_W*(y_pixel>>1) + (x_pixel>>1).
REQ-014 SHALL deem a cycle a display fetch slot when disp_en=1, x_pixel<640, y_pixel<480 and x_pixel[0]=0.
REQ-015 SHALL deem every other cycle a free slot; aux_gnt = aux_req AND free slot.
REQ-016 SHALL give display fetches absolute priority; an aux request never delays a display pixel.
REQ-017 SHALL register rom_addr at the end of the slot cycle t, with a 2-bit owner tag: IDLE, DISP or AUX.
REQ-018 SHALL register pixel and aux outputs at the end of cycle t+2, so all outputs are valid in cycle t+3, fixed latency 3.
REQ-019 SHALL map RGB565 to RGB444 as r=data[15:12], g=data[10:7], b=data[4:1].
REQ-020 SHALL hold the last display word; odd-x active pixels reuse it with the same 3-cycle latency and do not access the ROM.
REQ-021 SHALL output RGB 0 at t+3 when disp_en=0 or the coordinate is out of range at t.
REQ-022 SHALL pulse aux_rvalid for exactly one cycle at t+3 per grant, with aux_rdata=rom_data; aux_rdata holds until the next return.
REQ-023 SHALL grant aux_addr >= IMG_W*IMG_H, drive rom_addr=0, and return aux_rdata=16'h0000.
REQ-024 SHALL drive rom_addr 0 in IDLE slots, i.e. free with no aux_req.
REQ-025 SHALL support back-to-back aux grants in consecutive free cycles, one return each, in order.

Reset
REQ-026 SHALL on reset clear rom_addr, RGB, aux_rvalid, aux_rdata, the held word and all pipeline tags to 0/IDLE immediately.
REQ-027 SHALL discard any in-flight read when reset asserts mid-pipeline; no aux_rvalid follows reset release.

Structure
REQ-028 SHALL take IMG_W, IMG_H, ADDR_W=17 and the owner enum {IDLE, DISP, AUX} from shared package img_rom_pkg.
REQ-029 SHALL compute the display address in sub-module img_addr_calc, combinational, using (y<<8)+(y<<6)+x for IMG_W=320.

Verification
REQ-030 Display (0,0), then (1,0), with disp_en=1 and rom word 16'hF800 -> rom_addr=0; r=F, g=0, b=0 at t+3 and t+4; aux_gnt=0 at x=0, free at x=1.
REQ-031 Display (639,479) -> rom_addr=76799 fetched at x=638; x=639 repeats that word.
REQ-032 aux_req with addr 100 during blanking -> aux_gnt same cycle; aux_rvalid=1 three cycles later with ROM[100].
REQ-033 aux_req held across an active line -> grants only on odd-x and blanking cycles; displayed pixels match a golden model.
REQ-034 aux_addr=76800 -> granted; aux_rdata=0, rom_addr=0.
REQ-035 Reset asserted one cycle after an aux grant -> outputs 0 immediately; no aux_rvalid pulse after release.

Source files
------------

// File: rtl/img_rom_pkg.sv
// Shared constants and types for the image-ROM arbiter: default geometry, ROM
// address width, slot-owner tag and the RGB565 to RGB444 reduction.
package img_rom_pkg;

  localparam int IMG_W  = 320;
  localparam int IMG_H  = 240;
  localparam int ADDR_W = 17;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_AUX  = 2'd2
  } owner_e;

  // Travels with each ROM access: who owns the slot, whether the display pixel
  // of that slot is active, and whether an aux read must come back as zero.
  typedef struct packed {
    owner_e owner;
    logic   pix_act;
    logic   aux_zero;
  } slot_t;

  localparam slot_t SLOT_IDLE = '{owner: OWN_IDLE, pix_act: 1'b0, aux_zero: 1'b0};

  function automatic logic [11:0] rgb565_to_444(input logic [15:0] word);
    return {word[15:12], word[10:7], word[4:1]};
  endfunction

endpackage

// File: rtl/img_addr_calc.sv
// Source-image address for a 2x upscaled display: IMG_W * sy + sx, where sx/sy
// are the display coordinates already halved by the caller.
module img_addr_calc
  import img_rom_pkg::*;
#(
  parameter int IMG_W = img_rom_pkg::IMG_W
) (
  input  logic [8:0]        sx,
  input  logic [8:0]        sy,
  output logic [ADDR_W-1:0] addr
);

  generate
    if (IMG_W == 320) begin : g_shift_add
      // 320 = 256 + 64, so the multiply reduces to two shifted copies of sy.
      assign addr = {sy, 8'b0} + {2'b0, sy, 6'b0} + {8'b0, sx};
    end else begin : g_generic
      assign addr = ADDR_W'(IMG_W * int'(sy) + int'(sx));
    end
  endgenerate

endmodule

// File: rtl/img_rom_arbiter.sv
// Shares one single-port image ROM between the 2x-upscaling display path and
// an auxiliary reader; display fetches own every even active pixel.
module img_rom_arbiter
  import img_rom_pkg::*;
#(
  parameter int IMG_W = img_rom_pkg::IMG_W,
  parameter int IMG_H = img_rom_pkg::IMG_H
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_en,
  input  logic [9:0]        x_pixel,
  input  logic [9:0]        y_pixel,
  output logic [3:0]        r_port,
  output logic [3:0]        g_port,
  output logic [3:0]        b_port,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  input  logic              aux_req,
  input  logic [ADDR_W-1:0] aux_addr,
  output logic              aux_gnt,
  output logic              aux_rvalid,
  output logic [15:0]       aux_rdata
);

  localparam logic [ADDR_W-1:0] IMG_PIXELS = ADDR_W'(IMG_W * IMG_H);

  logic              pix_act;
  logic              disp_slot;
  logic              aux_in_range;
  logic [ADDR_W-1:0] disp_addr;
  logic [ADDR_W-1:0] addr_next;
  slot_t             slot_now;
  slot_t             slot_s1;
  slot_t             slot_s2;
  logic [15:0]       held_word;
  logic [15:0]       held_next;
  logic [11:0]       rgb_q;
  logic [11:0]       rgb_next;
  logic              rvalid_next;
  logic [15:0]       rdata_next;

  img_addr_calc #(.IMG_W(IMG_W)) u_addr_calc (
    .sx   (x_pixel[9:1]),
    .sy   (y_pixel[9:1]),
    .addr (disp_addr)
  );

  // Slot decision: display owns even active pixels, aux gets everything else.
  always_comb begin
    // NOTE: every variable gets a default first so no path through always_comb infers a latch.
    slot_now     = SLOT_IDLE;
    addr_next    = '0;
    pix_act      = disp_en && (x_pixel < 10'd640) && (y_pixel < 10'd480);
    disp_slot    = pix_act && !x_pixel[0];
    aux_gnt      = aux_req && !disp_slot;
    aux_in_range = aux_addr < IMG_PIXELS;

    slot_now.pix_act = pix_act;
    if (disp_slot) begin
      slot_now.owner = OWN_DISP;
      addr_next      = disp_addr;
    end else if (aux_gnt) begin
      slot_now.owner    = OWN_AUX;
      slot_now.aux_zero = !aux_in_range;
      addr_next         = aux_in_range ? aux_addr : '0;
    end
  end

  // Address stage plus one stage covering the ROM's own registered read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_addr <= '0;
      slot_s1  <= SLOT_IDLE;
      slot_s2  <= SLOT_IDLE;
    end else begin
      // NOTE: nonblocking assignments so each register samples pre-edge values and stages shift cleanly.
      rom_addr <= addr_next;
      slot_s1  <= slot_now;
      slot_s2  <= slot_s1;
    end
  end

  // rom_data now belongs to the slot tagged in slot_s2.
  always_comb begin
    held_next   = held_word;
    rgb_next    = '0;
    rvalid_next = 1'b0;
    rdata_next  = aux_rdata;

    if (slot_s2.owner == OWN_DISP) begin
      held_next = rom_data;
      rgb_next  = rgb565_to_444(rom_data);
    end else if (slot_s2.pix_act) begin
      rgb_next = rgb565_to_444(held_word);
    end

    if (slot_s2.owner == OWN_AUX) begin
      rvalid_next = 1'b1;
      rdata_next  = slot_s2.aux_zero ? 16'h0000 : rom_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_word  <= '0;
      rgb_q      <= '0;
      aux_rvalid <= 1'b0;
      aux_rdata  <= '0;
    end else begin
      held_word  <= held_next;
      rgb_q      <= rgb_next;
      aux_rvalid <= rvalid_next;
      aux_rdata  <= rdata_next;
    end
  end

  assign {r_port, g_port, b_port} = rgb_q;

endmodule

// File: tb/tb_img_rom_arbiter.sv
// Self-checking bench: directed boundary cases then randomized scan/aux traffic,
// compared every cycle against a slot-by-slot behavioural model.
module tb_img_rom_arbiter;

  localparam int IMG_W = 320;
  localparam int IMG_H = 240;
  localparam int NPIX  = IMG_W * IMG_H;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        disp_en = 1'b0;
  logic [9:0]  x_pixel = '0;
  logic [9:0]  y_pixel = '0;
  logic [3:0]  r_port, g_port, b_port;
  logic [16:0] rom_addr;
  logic [15:0] rom_data;
  logic        aux_req = 1'b0;
  logic [16:0] aux_addr = '0;
  logic        aux_gnt;
  logic        aux_rvalid;
  logic [15:0] aux_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Expected outputs per cycle, ring of 8 indexed by cycle number.
  logic [16:0] e_addr [8];
  logic [11:0] e_rgb  [8];
  logic        e_rv   [8];
  logic [15:0] e_rd   [8];
  logic [15:0] m_held  = '0;
  logic [15:0] m_rdata = '0;

  always #5 clk = ~clk;

  img_rom_arbiter #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk        (clk),
    .reset      (reset),
    .disp_en    (disp_en),
    .x_pixel    (x_pixel),
    .y_pixel    (y_pixel),
    .r_port     (r_port),
    .g_port     (g_port),
    .b_port     (b_port),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .aux_req    (aux_req),
    .aux_addr   (aux_addr),
    .aux_gnt    (aux_gnt),
    .aux_rvalid (aux_rvalid),
    .aux_rdata  (aux_rdata)
  );

  function automatic logic [15:0] rom_fn(input int a);
    int h;
    case (a)
      0:       return 16'hF800;
      100:     return 16'h1234;
      76799:   return 16'h07E0;
      default: begin
        h = (a * 40503) ^ (a >> 3) ^ 16'h5A5A;
        return h[15:0];
      end
    endcase
  endfunction

  // Image ROM with a one-cycle registered read.
  always @(posedge clk) rom_data <= rom_fn(int'(rom_addr));

  function automatic logic [11:0] to444(input logic [15:0] d);
    return {d[15:12], d[10:7], d[4:1]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // One clock cycle: check registered outputs, drive inputs, check aux_gnt,
  // then project this slot's effect onto the model's future cycles.
  task automatic step(input logic rst_v, input logic d, input int x, input int y,
                      input logic ar, input int aa);
    int  s, s1, s3, addr;
    logic active, fetch, gnt;
    @(posedge clk);
    #1;
    s = cyc % 8;
    check("rom_addr",   32'(rom_addr),   32'(e_addr[s]));
    check("rgb",        32'({r_port, g_port, b_port}), 32'(e_rgb[s]));
    check("aux_rvalid", 32'(aux_rvalid), 32'(e_rv[s]));
    check("aux_rdata",  32'(aux_rdata),  32'(e_rd[s]));

    reset    = rst_v;
    disp_en  = d;
    x_pixel  = 10'(x);
    y_pixel  = 10'(y);
    aux_req  = ar;
    aux_addr = 17'(aa);
    #1;
    active = d && (x < 640) && (y < 480);
    fetch  = active && (x % 2 == 0);
    gnt    = ar && !fetch;
    check("aux_gnt", 32'(aux_gnt), 32'(gnt));

    if (rst_v) begin
      m_held  = '0;
      m_rdata = '0;
      for (int k = 1; k <= 3; k++) begin
        e_addr[(cyc + k) % 8] = '0;
        e_rgb[(cyc + k) % 8]  = '0;
        e_rv[(cyc + k) % 8]   = 1'b0;
        e_rd[(cyc + k) % 8]   = '0;
      end
      check("rst_rom_addr", 32'(rom_addr), 32'd0);
      check("rst_rgb",      32'({r_port, g_port, b_port}), 32'd0);
      check("rst_rvalid",   32'(aux_rvalid), 32'd0);
      check("rst_rdata",    32'(aux_rdata), 32'd0);
    end else begin
      s1 = (cyc + 1) % 8;
      s3 = (cyc + 3) % 8;
      if (fetch) begin
        addr      = IMG_W * (y / 2) + (x / 2);
        m_held    = rom_fn(addr);
        e_addr[s1] = 17'(addr);
      end else if (gnt && aa < NPIX) begin
        e_addr[s1] = 17'(aa);
      end else begin
        e_addr[s1] = '0;
      end
      e_rgb[s3] = active ? to444(m_held) : 12'h000;
      if (gnt) m_rdata = (aa < NPIX) ? rom_fn(aa) : 16'h0000;
      e_rv[s3] = gnt;
      e_rd[s3] = m_rdata;
    end
    cyc++;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 700, 500, 1'b0, 0);
  endtask

  int   hx, hy, x, y, aa;
  logic d, ar, last_gnt;

  initial begin
    for (int i = 0; i < 8; i++) begin
      e_addr[i] = '0;
      e_rgb[i]  = '0;
      e_rv[i]   = 1'b0;
      e_rd[i]   = '0;
    end
    repeat (3) step(1'b1, 1'b0, 0, 0, 1'b0, 0);

    // Pixel (0,0) then (1,0): fetch on even x, aux waits, reuse on odd x.
    step(1'b0, 1'b1, 0, 0, 1'b1, 5);
    check("gnt_at_x0", 32'(aux_gnt), 32'd0);
    step(1'b0, 1'b1, 1, 0, 1'b1, 5);
    check("gnt_at_x1", 32'(aux_gnt), 32'd1);
    check("addr_pix00", 32'(rom_addr), 32'd0);
    idle();
    idle();
    check("rgb_pix00", 32'({r_port, g_port, b_port}), 32'hF00);
    idle();
    check("rgb_pix10", 32'({r_port, g_port, b_port}), 32'hF00);

    // Bottom-right corner.
    step(1'b0, 1'b1, 638, 479, 1'b0, 0);
    step(1'b0, 1'b1, 639, 479, 1'b0, 0);
    check("addr_corner", 32'(rom_addr), 32'd76799);
    idle();
    idle();
    check("rgb_638", 32'({r_port, g_port, b_port}), 32'h0F0);
    idle();
    check("rgb_639", 32'({r_port, g_port, b_port}), 32'h0F0);

    // Aux read of address 100 in blanking.
    step(1'b0, 1'b0, 700, 500, 1'b1, 100);
    check("gnt_blank", 32'(aux_gnt), 32'd1);
    idle();
    check("addr_aux100", 32'(rom_addr), 32'd100);
    idle();
    idle();
    check("rvalid_aux100", 32'(aux_rvalid), 32'd1);
    check("rdata_aux100", 32'(aux_rdata), 32'h1234);
    idle();
    check("rvalid_pulse", 32'(aux_rvalid), 32'd0);
    check("rdata_hold", 32'(aux_rdata), 32'h1234);

    // Aux address beyond the image.
    step(1'b0, 1'b0, 700, 500, 1'b1, 76800);
    check("gnt_oob", 32'(aux_gnt), 32'd1);
    idle();
    check("addr_oob", 32'(rom_addr), 32'd0);
    idle();
    idle();
    check("rvalid_oob", 32'(aux_rvalid), 32'd1);
    check("rdata_oob", 32'(aux_rdata), 32'h0000);

    // Back-to-back aux grants.
    step(1'b0, 1'b0, 700, 500, 1'b1, 200);
    step(1'b0, 1'b0, 700, 500, 1'b1, 201);
    step(1'b0, 1'b0, 700, 500, 1'b1, 202);
    repeat (4) idle();

    // Reset one cycle after an aux grant, with a visible pixel in flight.
    step(1'b0, 1'b1, 0, 0, 1'b0, 0);
    step(1'b0, 1'b1, 1, 0, 1'b1, 100);
    step(1'b0, 1'b1, 2, 0, 1'b0, 0);
    step(1'b1, 1'b0, 0, 0, 1'b0, 0);
    check("rst_immediate_rgb", 32'({r_port, g_port, b_port}), 32'h000);
    for (int i = 0; i < 5; i++) begin
      idle();
      check("no_rvalid_after_rst", 32'(aux_rvalid), 32'd0);
    end

    // Randomized scan with gating glitches, wild coordinates and aux traffic.
    hx = 560;
    hy = 470;
    ar = 1'b0;
    aa = 0;
    last_gnt = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      hx++;
      if (hx == 800) begin
        hx = 0;
        hy = (hy + 1) % 525;
      end
      d = (hx < 640) && (hy < 480);
      if ($urandom_range(0, 15) == 0) d = !d;
      x = hx;
      y = hy;
      if ($urandom_range(0, 19) == 0) begin
        x = int'($urandom_range(0, 1023));
        y = int'($urandom_range(0, 1023));
      end
      if (!ar || last_gnt) begin
        if (ar && $urandom_range(0, 2) == 0) ar = 1'b0;
        else if (ar || $urandom_range(0, 3) == 0) begin
          ar = 1'b1;
          aa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(76800, 131071))
                                           : int'($urandom_range(0, 76799));
        end
      end
      if ($urandom_range(0, 799) == 0) begin
        step(1'b1, d, x, y, 1'b0, aa);
        ar = 1'b0;
        last_gnt = 1'b0;
      end else begin
        step(1'b0, d, x, y, ar, aa);
        last_gnt = aux_gnt;
      end
    end
    repeat (4) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
